// File: rtl/segasys1_snd_cmd_queue.sv
// ---------------------------------------------------------------------------
// segasys1_snd_cmd_queue
//
// Sound-command front end for the SEGA System 1 sound CPU. Commands strobed
// by the main CPU are queued in a small FIFO and presented one at a time on
// comlatch. Each presentation raises an NMI to the sound Z80. The command is
// retired when the Z80 reads the latch. The block also generates the
// periodic sound-CPU IRQ.
//
// Ports
//   clk          sound clock (4 MHz nominal)
//   reset_n      asynchronous reset, active low
//   sndno        command byte from the main CPU
//   sndstart     command strobe; each rising edge pushes sndno
//   com_rd       one-cycle pulse when the Z80 reads the command latch
//   cpu_irq      periodic IRQ request to the sound Z80
//   cpu_irqa     IRQ acknowledge
//   cpu_nmi      NMI request, raised on each presented command
//   cpu_nmia     NMI acknowledge
//   comlatch     command currently presented to the Z80
//   cmd_pending  comlatch holds a command that has not been read yet
//   fifo_count   entries waiting in the FIFO (the presented one excluded)
//   overflow     sticky flag: a push was dropped because the FIFO was full
//   ovf_clr      clears overflow
// ---------------------------------------------------------------------------
module segasys1_snd_cmd_queue #(
  parameter int DW         = 8,
  parameter int DEPTH      = 4,
  parameter int IRQ_PERIOD = 16667,
  parameter bit IRQ_EN     = 1'b1,
  parameter bit NMI_MODE   = 1'b0,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] sndno,
  input  logic          sndstart,
  input  logic          com_rd,
  output logic          cpu_irq,
  input  logic          cpu_irqa,
  output logic          cpu_nmi,
  input  logic          cpu_nmia,
  output logic [DW-1:0] comlatch,
  output logic          cmd_pending,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam int IW = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;
  localparam logic [IW-1:0] IRQ_LAST = IW'(IRQ_PERIOD - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic          prev_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  state_t        state_q;
  logic [DW-1:0] latch_q;
  logic          pending_q;
  logic          nmi_q;
  logic          irq_q;
  logic [IW-1:0] cnt_q;
  logic          ovf_q;
  logic [DW-1:0] mem_q [DEPTH];

  // -------------------------------------------------------------------------
  // Push / pop decode
  // -------------------------------------------------------------------------
  logic push, pop, accept, drop;

  assign push   = sndstart & ~prev_q;
  assign pop    = (state_q == S_IDLE) && (count_q != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept = push && ((count_q < CW'(DEPTH)) || pop);
  assign drop   = push && !accept;

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      prev_q   <= sndstart;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked
  // by the pointers and count, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= sndno;
  end

  // -------------------------------------------------------------------------
  // Presentation FSM with registered latch, pending and NMI
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      latch_q   <= '0;
      pending_q <= 1'b0;
      nmi_q     <= 1'b0;
    end else begin
      // Acknowledge first so that a new presentation below overrides it.
      if (cpu_nmia) nmi_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            latch_q   <= mem_q[rd_ptr_q];
            pending_q <= 1'b1;
            if (!NMI_MODE) nmi_q <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // comlatch keeps the last command after it has been read.
          if (com_rd) begin
            pending_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Periodic IRQ and sticky overflow
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      // The counter free-runs; acknowledges never disturb its phase.
      if (cnt_q == IRQ_LAST) cnt_q <= '0;
      else                   cnt_q <= cnt_q + IW'(1);

      if ((cnt_q == IRQ_LAST) && IRQ_EN) irq_q <= 1'b1;
      else if (cpu_irqa)                 irq_q <= 1'b0;

      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign cpu_irq     = irq_q;
  assign cpu_nmi     = nmi_q;
  assign comlatch    = latch_q;
  assign cmd_pending = pending_q;
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;

endmodule
